// File: rtl/jk_seq_pkg.sv
// Shared opcode and FSM state definitions for the JK bank sequencer.
package jk_seq_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_CLEAR = 3'd1;
  localparam logic [2:0] OP_SET   = 3'd2;
  localparam logic [2:0] OP_INV   = 3'd3;
  localparam logic [2:0] OP_LOAD  = 3'd4;
  localparam logic [2:0] OP_UP    = 3'd5;
  localparam logic [2:0] OP_DOWN  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/jk_bank_sequencer_cell.sv
// Single JK flip-flop: 00 hold, 01 clear, 10 set, 11 toggle; async active-low reset to 0.
module jk_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qb
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

  assign qb = ~q;

endmodule

// File: rtl/jk_bank_sequencer.sv
// Command-driven sequencer that drives a bank of JK flip-flops for a programmed
// number of edges per accepted command, reporting done and counter wrap.
module jk_bank_sequencer
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  state_e           state_q;
  logic [LEN_W-1:0] rem_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic             done_q;
  logic             wrap_q;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] t_up;
  logic [WIDTH-1:0] t_dn;
  logic             accept;

  assign accept    = cmd_valid && (state_q == IDLE);
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign wrap      = wrap_q;

  // Ripple toggle enables: a bit flips when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    t_up    = '0;
    t_dn    = '0;
    t_up[0] = 1'b1;
    t_dn[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      t_up[i] = t_up[i-1] & q[i-1];
      t_dn[i] = t_dn[i-1] & ~q[i-1];
    end
  end

  always_comb begin
    j = '0;
    k = '0;
    if (state_q == RUN) begin
      case (op_q)
        OP_CLEAR: k = '1;
        OP_SET:   j = '1;
        OP_INV:   begin j = '1;     k = '1;      end
        OP_LOAD:  begin j = data_q; k = ~data_q; end
        OP_UP:    begin j = t_up;   k = t_up;    end
        OP_DOWN:  begin j = t_dn;   k = t_dn;    end
        default:  begin j = '0;     k = '0;      end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      op_q    <= OP_NOP;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q    <= cmd_op;
            rem_q   <= (cmd_len == '0) ? LEN_W'(1) : cmd_len;
            state_q <= RUN;
          end
        end
        RUN: begin
          wrap_q <= ((op_q == OP_UP) && (&q)) || ((op_q == OP_DOWN) && !(|q));
          if (rem_q == LEN_W'(1)) begin
            rem_q   <= '0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            rem_q <= rem_q - LEN_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Load value is only consumed while RUN, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) data_q <= cmd_data;
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .j     (j[g]),
      .k     (k[g]),
      .q     (q[g]),
      .qb    (qb[g])
    );
  end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed self-checking bench for jk_bank_sequencer (WIDTH=4, LEN_W=8).
module tb_jk_bank_sequencer;
  import jk_seq_pkg::*;

  localparam int WIDTH = 4;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [LEN_W-1:0] cmd_len;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic             busy;
  logic             done;
  logic             wrap;

  int n_tests = 0;
  int n_fail  = 0;

  jk_bank_sequencer #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_len   (cmd_len),
    .q         (q),
    .qb        (qb),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for ready, presents the command for exactly one accept edge.
  task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] data, input logic [LEN_W-1:0] len);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    check("send_ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_op    = op;
    cmd_data  = data;
    cmd_len   = len;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  logic [WIDTH-1:0] seq_up [7];
  logic             wr_up  [7];
  int               n_edges;

  initial begin
    seq_up = '{4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1};
    wr_up  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_data = '0; cmd_len = '0;
    #22 rst_n = 1'b1;
    step();
    check("rst_q", 32'(q), 32'h0);
    check("rst_ready", 32'(cmd_ready), 32'd1);

    // LOAD A len 1
    send(OP_LOAD, 4'hA, 8'd1);
    check("load_busy0", 32'(busy), 32'd1);
    step();
    check("load_q", 32'(q), 32'hA);
    check("load_done", 32'(done), 32'd1);
    check("load_ready_low", 32'(cmd_ready), 32'd0);
    step();
    check("load_done_clr", 32'(done), 32'd0);
    check("load_ready", 32'(cmd_ready), 32'd1);

    // Async reset mid-cycle during a running command
    send(OP_LOAD, 4'h5, 8'd3);
    step();
    check("arst_pre_q", 32'(q), 32'h5);
    #2 rst_n = 1'b0;
    #1;
    check("arst_q", 32'(q), 32'h0);
    check("arst_qb", 32'(qb), 32'hF);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ready", 32'(cmd_ready), 32'd1);
    check("arst_done", 32'(done), 32'd0);
    #1 rst_n = 1'b1;
    step();

    // UP len 7 from A
    send(OP_LOAD, 4'hA, 8'd1);
    step(); step();
    send(OP_UP, 4'h0, 8'd7);
    for (int i = 0; i < 7; i++) begin
      step();
      check($sformatf("up_q%0d", i), 32'(q), 32'(seq_up[i]));
      check($sformatf("up_wrap%0d", i), 32'(wrap), 32'(wr_up[i]));
      check($sformatf("up_done%0d", i), 32'(done), (i == 6) ? 32'd1 : 32'd0);
    end
    step();
    check("up_ready", 32'(cmd_ready), 32'd1);
    check("up_qb", 32'(qb), 32'hE);

    // DOWN len 2 from 0
    send(OP_CLEAR, 4'h0, 8'd1);
    step(); step();
    send(OP_DOWN, 4'h0, 8'd2);
    step();
    check("dn_q1", 32'(q), 32'hF);
    check("dn_wrap1", 32'(wrap), 32'd1);
    step();
    check("dn_q2", 32'(q), 32'hE);
    check("dn_wrap2", 32'(wrap), 32'd0);
    check("dn_done", 32'(done), 32'd1);
    step();

    // INV len 3 from 5
    send(OP_LOAD, 4'h5, 8'd1);
    step(); step();
    send(OP_INV, 4'h0, 8'd3);
    step(); check("inv_q1", 32'(q), 32'hA);
    step(); check("inv_q2", 32'(q), 32'h5);
    step(); check("inv_q3", 32'(q), 32'hA);
    check("inv_done", 32'(done), 32'd1);
    check("inv_wrap", 32'(wrap), 32'd0);
    step();

    // CLEAR len 0 acts as len 1
    send(OP_CLEAR, 4'hF, 8'd0);
    step();
    check("clr0_q", 32'(q), 32'h0);
    check("clr0_done", 32'(done), 32'd1);
    step();
    check("clr0_ready", 32'(cmd_ready), 32'd1);

    // Reserved opcode holds q and still runs its edges
    send(OP_LOAD, 4'h6, 8'd1);
    step(); step();
    send(OP_RSVD, 4'h0, 8'd2);
    step();
    check("rsvd_q1", 32'(q), 32'h6);
    check("rsvd_done1", 32'(done), 32'd0);
    step();
    check("rsvd_done2", 32'(done), 32'd1);
    step();

    // SET held while UP len 5 runs from 0
    send(OP_CLEAR, 4'h0, 8'd1);
    step(); step();
    send(OP_UP, 4'h0, 8'd5);
    cmd_op = OP_SET; cmd_data = 4'h0; cmd_len = 8'd1; cmd_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      check($sformatf("hold_q%0d", i), 32'(q), 32'(i));
      check($sformatf("hold_ready%0d", i), 32'(cmd_ready), 32'd0);
    end
    step();
    check("hold_ready_back", 32'(cmd_ready), 32'd1);
    check("hold_q_kept", 32'(q), 32'h5);
    step();
    cmd_valid = 1'b0;
    check("hold_accept_busy", 32'(busy), 32'd1);
    check("hold_accept_q", 32'(q), 32'h5);
    step();
    check("set_q", 32'(q), 32'hF);
    check("set_done", 32'(done), 32'd1);
    step();

    // Maximum length 255: UP from 0 ends at 255 mod 16 = F after exactly 255 edges
    send(OP_CLEAR, 4'h0, 8'd1);
    step(); step();
    send(OP_UP, 4'h0, 8'd255);
    n_edges = 0;
    do begin
      step();
      n_edges++;
    end while (!done && n_edges < 300);
    check("max_edges", 32'(n_edges), 32'd255);
    check("max_q", 32'(q), 32'hF);
    step();
    check("max_ready", 32'(cmd_ready), 32'd1);

    // Reset across edge 3 of UP len 10 aborts without done
    send(OP_CLEAR, 4'h0, 8'd1);
    step(); step();
    send(OP_UP, 4'h0, 8'd10);
    step(); step();
    check("abort_pre_q", 32'(q), 32'h2);
    #2 rst_n = 1'b0;
    step();
    check("abort_q", 32'(q), 32'h0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    step();
    check("abort_done_later", 32'(done), 32'd0);
    check("abort_q_later", 32'(q), 32'h0);
    send(OP_LOAD, 4'h3, 8'd1);
    step();
    check("post_abort_q", 32'(q), 32'h3);
    check("post_abort_done", 32'(done), 32'd1);
    step();
    check("post_abort_ready", 32'(cmd_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
